axi_write_arbiter: RTL and testbench

Shares one AXI4 write master port (AW/W/B) between N_REQ cache write channels, e.g. the L1 data cache's write-through buffer and an L2 write-back evictor. Requesters are AXI write masters; the winner owns all three channels from the AW handshake until its B response completes. Round-robin arbitration is a build option. The block sits between the cache write channels and the system interconnect.

---
 rtl/axi_write_arbiter_if.sv | 76 +++++++
 rtl/axi_write_arbiter.sv | 144 ++++++++++++++
 tb/tb_axi_write_arbiter.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/axi_write_arbiter_if.sv
// Bundle of the N requester-side AXI write channels plus the shared master AW/W/B port.
// master: the arbiter, which drives the shared port; slave: the requesters and interconnect.
interface axi_write_arbiter_if #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int N_REQ    = 2,
    parameter int AXI_ID_W = 1
);
    localparam int NBYTES = DATA_W / 8;

    logic [N_REQ-1:0]        s_awvalid;
    logic [N_REQ*ADDR_W-1:0] s_awaddr;
    logic [N_REQ*8-1:0]      s_awlen;
    logic [N_REQ*3-1:0]      s_awsize;
    logic [N_REQ*2-1:0]      s_awburst;
    logic [N_REQ-1:0]        s_awready;
    logic [N_REQ-1:0]        s_wvalid;
    logic [N_REQ*DATA_W-1:0] s_wdata;
    logic [N_REQ*NBYTES-1:0] s_wstrb;
    logic [N_REQ-1:0]        s_wready;
    logic [N_REQ-1:0]        s_bvalid;
    logic [1:0]              s_bresp;
    logic [N_REQ-1:0]        s_bready;

    logic                    m_awvalid;
    logic [ADDR_W-1:0]       m_awaddr;
    logic [7:0]              m_awlen;
    logic [2:0]              m_awsize;
    logic [1:0]              m_awburst;
    logic [AXI_ID_W-1:0]     m_awid;
    logic                    m_awlock;
    logic [3:0]              m_awcache;
    logic [2:0]              m_awprot;
    logic [3:0]              m_awqos;
    logic                    m_awready;
    logic                    m_wvalid;
    logic [DATA_W-1:0]       m_wdata;
    logic [NBYTES-1:0]       m_wstrb;
    logic                    m_wlast;
    logic                    m_wready;
    logic                    m_bvalid;
    logic [1:0]              m_bresp;
    logic                    m_bready;

    modport master (
        input  s_awvalid, s_awaddr, s_awlen, s_awsize, s_awburst,
        output s_awready,
        input  s_wvalid, s_wdata, s_wstrb,
        output s_wready,
        output s_bvalid, s_bresp,
        input  s_bready,
        output m_awvalid, m_awaddr, m_awlen, m_awsize, m_awburst, m_awid,
        output m_awlock, m_awcache, m_awprot, m_awqos,
        input  m_awready,
        output m_wvalid, m_wdata, m_wstrb, m_wlast,
        input  m_wready,
        input  m_bvalid, m_bresp,
        output m_bready
    );

    modport slave (
        output s_awvalid, s_awaddr, s_awlen, s_awsize, s_awburst,
        input  s_awready,
        output s_wvalid, s_wdata, s_wstrb,
        input  s_wready,
        input  s_bvalid, s_bresp,
        output s_bready,
        input  m_awvalid, m_awaddr, m_awlen, m_awsize, m_awburst, m_awid,
        input  m_awlock, m_awcache, m_awprot, m_awqos,
        output m_awready,
        input  m_wvalid, m_wdata, m_wstrb, m_wlast,
        output m_wready,
        output m_bvalid, m_bresp,
        input  m_bready
    );
endinterface

// File: rtl/axi_write_arbiter.sv
// Shares one AXI4 write port among N_REQ requesters; AXI_WARB_RR_EN selects round-robin over fixed priority.
// Latency: one cycle arbitration in IDLE, then AW/W/B pass through combinationally from the granted requester.
// Backpressure: m_awready/m_wready/s_bready are forwarded to/from the granted requester only; others see ready=0.
module axi_write_arbiter #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int NBYTES   = DATA_W / 8,
    parameter int N_REQ    = 2,
    parameter int REQ_W    = $clog2(N_REQ),
    parameter int AXI_ID_W = 1,
    parameter int AXI_ID   = 0
) (
    input  logic                clk,
    input  logic                reset,
    axi_write_arbiter_if.master bus
);
    typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;

    state_t           state, state_nxt;
    logic [REQ_W-1:0] g, g_nxt, ptr, ptr_nxt, win, idx;
    logic [7:0]       len, len_nxt, cnt, cnt_nxt;
    logic             win_vld;
    logic [N_REQ-1:0] g_oh;

    logic [ADDR_W-1:0] awaddr_a  [N_REQ];
    logic [7:0]        awlen_a   [N_REQ];
    logic [2:0]        awsize_a  [N_REQ];
    logic [1:0]        awburst_a [N_REQ];
    logic [DATA_W-1:0] wdata_a   [N_REQ];
    logic [NBYTES-1:0] wstrb_a   [N_REQ];

    for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
        assign awaddr_a[i]  = bus.s_awaddr[i*ADDR_W +: ADDR_W];
        assign awlen_a[i]   = bus.s_awlen[i*8 +: 8];
        assign awsize_a[i]  = bus.s_awsize[i*3 +: 3];
        assign awburst_a[i] = bus.s_awburst[i*2 +: 2];
        assign wdata_a[i]   = bus.s_wdata[i*DATA_W +: DATA_W];
        assign wstrb_a[i]   = bus.s_wstrb[i*NBYTES +: NBYTES];
    end

    assign g_oh          = N_REQ'(1) << g;
    assign bus.m_awid    = AXI_ID_W'(AXI_ID);
    assign bus.m_awlock  = 1'b0;
    assign bus.m_awcache = 4'b0011;
    assign bus.m_awprot  = 3'b000;
    assign bus.m_awqos   = 4'b0000;

    // Scan starts at ptr and wraps; with fixed priority ptr never leaves 0.
    always_comb begin
        win     = '0;
        win_vld = 1'b0;
        idx     = '0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = REQ_W'((int'(ptr) + k) % N_REQ);
            if (!win_vld && bus.s_awvalid[idx]) begin
                win     = idx;
                win_vld = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            g     <= '0;
            ptr   <= '0;
            len   <= '0;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            g     <= g_nxt;
            ptr   <= ptr_nxt;
            len   <= len_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        g_nxt         = g;
        ptr_nxt       = ptr;
        len_nxt       = len;
        cnt_nxt       = cnt;
        bus.m_awvalid = 1'b0;
        bus.m_awaddr  = '0;
        bus.m_awlen   = '0;
        bus.m_awsize  = '0;
        bus.m_awburst = '0;
        bus.s_awready = '0;
        bus.m_wvalid  = 1'b0;
        bus.m_wdata   = '0;
        bus.m_wstrb   = '0;
        bus.m_wlast   = 1'b0;
        bus.s_wready  = '0;
        bus.s_bvalid  = '0;
        bus.s_bresp   = '0;
        bus.m_bready  = 1'b0;
        unique case (state)
            IDLE: begin
                if (win_vld) begin
                    g_nxt     = win;
                    len_nxt   = awlen_a[win];
                    cnt_nxt   = '0;
                    state_nxt = ADDR;
                end
            end
            ADDR: begin
                // A requester dropping awvalid here keeps the grant; we simply wait.
                bus.m_awvalid = bus.s_awvalid[g];
                bus.m_awaddr  = awaddr_a[g];
                bus.m_awlen   = awlen_a[g];
                bus.m_awsize  = awsize_a[g];
                bus.m_awburst = awburst_a[g];
                bus.s_awready = g_oh & {N_REQ{bus.m_awready}};
                if (bus.s_awvalid[g] && bus.m_awready) state_nxt = DATA;
            end
            DATA: begin
                bus.m_wvalid = bus.s_wvalid[g];
                bus.m_wdata  = wdata_a[g];
                bus.m_wstrb  = wstrb_a[g];
                bus.m_wlast  = bus.s_wvalid[g] && (cnt == len);
                bus.s_wready = g_oh & {N_REQ{bus.m_wready}};
                if (bus.s_wvalid[g] && bus.m_wready) begin
                    cnt_nxt = cnt + 8'd1;
                    if (cnt == len) state_nxt = RESP;
                end
            end
            RESP: begin
                bus.s_bvalid = g_oh & {N_REQ{bus.m_bvalid}};
                bus.s_bresp  = bus.m_bresp;
                bus.m_bready = bus.s_bready[g];
                if (bus.m_bvalid && bus.s_bready[g]) begin
                    state_nxt = IDLE;
`ifdef AXI_WARB_RR_EN
                    ptr_nxt = (g == REQ_W'(N_REQ - 1)) ? '0 : g + 1'b1;
`else
                    ptr_nxt = '0;
`endif
                end
            end
            default: state_nxt = IDLE;
        endcase
    end
endmodule

// File: tb/tb_axi_write_arbiter.sv
// Directed bench for axi_write_arbiter: scoreboard queues hold expected AW, W and grant order.
module tb_axi_write_arbiter;
    localparam int ADDR_W = 32, DATA_W = 32, NBYTES = 4, N_REQ = 2, REQ_W = 1, AXI_ID_W = 1;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    axi_write_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .N_REQ(N_REQ), .AXI_ID_W(AXI_ID_W)) bus ();

    axi_write_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .NBYTES(NBYTES), .N_REQ(N_REQ),
        .REQ_W(REQ_W), .AXI_ID_W(AXI_ID_W), .AXI_ID(0)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    int total = 0;
    int bad = 0;
    logic [39:0] awq[$];
    logic [32:0] wq[$];
    int gq[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.s_awvalid = '0; bus.s_awaddr = '0; bus.s_awlen = '0; bus.s_awsize = '0;
        bus.s_awburst = '0; bus.s_wvalid = '0; bus.s_wdata = '0; bus.s_wstrb = '0;
        bus.s_bready = '0; bus.m_awready = 1'b0; bus.m_wready = 1'b0;
        bus.m_bvalid = 1'b0; bus.m_bresp = 2'b00;
    endtask

    task automatic check_quiet(input string tag);
        chk({tag, "_awvalid"}, bus.m_awvalid, 0);
        chk({tag, "_wvalid"}, bus.m_wvalid, 0);
        chk({tag, "_wlast"}, bus.m_wlast, 0);
        chk({tag, "_bready"}, bus.m_bready, 0);
        chk({tag, "_s_awready"}, bus.s_awready, 0);
        chk({tag, "_s_wready"}, bus.s_wready, 0);
        chk({tag, "_s_bvalid"}, bus.s_bvalid, 0);
        chk({tag, "_awcache"}, bus.m_awcache, 4'b0011);
    endtask

    // One requester-r transaction with the bench acting as both requester and interconnect.
    task automatic do_xact(input int r, input logic [31:0] addr, input logic [7:0] len,
                           input logic [1:0] bresp, input int aw_stall, input bit wtog);
        int cyc = 0;
        int beats = 0;
        bit aw_done = 0;
        bit b_done = 0;
        logic [N_REQ-1:0] oh;
        logic [31:0] base;
        logic [39:0] ea;
        logic [32:0] ew;
        oh = N_REQ'(1) << r;
        base = addr ^ 32'hA5A5_0000;
        awq.push_back({len, addr});
        for (int b = 0; b <= int'(len); b++) wq.push_back({(b == int'(len)), base + b});
        while (!b_done && cyc < 300) begin
            @(negedge clk);
            bus.s_awvalid = aw_done ? '0 : oh;
            bus.s_awaddr[r*ADDR_W +: ADDR_W] = addr;
            bus.s_awlen[r*8 +: 8] = len;
            bus.s_awsize[r*3 +: 3] = 3'd2;
            bus.s_awburst[r*2 +: 2] = 2'b01;
            bus.s_wvalid = (aw_done && beats <= int'(len)) ? oh : '0;
            bus.s_wdata[r*DATA_W +: DATA_W] = base + beats;
            bus.s_wstrb[r*NBYTES +: NBYTES] = '1;
            bus.s_bready = oh;
            bus.m_awready = (cyc > aw_stall);
            bus.m_wready = wtog ? cyc[0] : 1'b1;
            bus.m_bvalid = (beats > int'(len));
            bus.m_bresp = bresp;
            #1;
            if (aw_stall > 0 && cyc >= 1 && cyc <= aw_stall) begin
                chk("aw_hold_vld", bus.m_awvalid, 1);
                chk("aw_hold_addr", bus.m_awaddr, addr);
                chk("no_w_before_aw", bus.m_wvalid | (|bus.s_wready), 0);
            end
            if (wtog) chk("wready_other", bus.s_wready & ~oh, 0);
            if (bus.m_awvalid && bus.m_awready) begin
                ea = awq.pop_front();
                chk("aw_addr", bus.m_awaddr, ea[31:0]);
                chk("aw_len", bus.m_awlen, ea[39:32]);
                chk("s_awready", bus.s_awready, oh);
                if (aw_stall == 0) chk("arb_latency", cyc, 1);
                aw_done = 1;
            end
            if (bus.m_wvalid) chk("wlast_level", bus.m_wlast, (beats == int'(len)));
            if (bus.m_wvalid && bus.m_wready) begin
                if (wq.size() == 0) chk("w_extra_beat", 1, 0);
                else begin
                    ew = wq.pop_front();
                    chk("wdata", bus.m_wdata, ew[31:0]);
                    chk("wlast_beat", bus.m_wlast, ew[32]);
                    chk("s_wready", bus.s_wready, oh);
                end
                beats++;
            end
            if (bus.m_bvalid && bus.m_bready) begin
                chk("s_bvalid", bus.s_bvalid, oh);
                chk("s_bresp", bus.s_bresp, bresp);
                b_done = 1;
            end
            cyc++;
        end
        if (!b_done) chk("xact_timeout", 0, 1);
        chk("w_beat_count", beats, int'(len) + 1);
        @(negedge clk);
        idle_inputs();
        #1;
        chk("idle_after_b", bus.m_awvalid, 0);
    endtask

    initial begin
        int cyc;
        int n;
        int gw;
        idle_inputs();
        repeat (3) @(negedge clk);
        #1;
        check_quiet("reset");
        chk("reset_awid", bus.m_awid, 0);
        chk("reset_awaddr", bus.m_awaddr, 0);
        reset = 1'b1;

        // single write from requester 1
        do_xact(1, 32'h100, 8'd0, 2'b00, 0, 0);
        // burst of 4 from requester 0 with wready toggling
        do_xact(0, 32'h180, 8'd3, 2'b00, 0, 1);
        // error response then retry at the same address
        do_xact(0, 32'h200, 8'd1, 2'b10, 0, 0);
        do_xact(0, 32'h200, 8'd1, 2'b00, 0, 0);
        // AW back-pressure for 10 cycles
        do_xact(1, 32'h5000, 8'd1, 2'b00, 10, 0);

        // simultaneous requests, four grants
`ifdef AXI_WARB_RR_EN
        gq.push_back(0); gq.push_back(1); gq.push_back(0); gq.push_back(1);
`else
        gq.push_back(0); gq.push_back(0); gq.push_back(0); gq.push_back(0);
`endif
        @(negedge clk);
        bus.s_awvalid = '1;
        bus.s_awaddr = {32'h2000, 32'h1000};
        bus.s_awlen = '0;
        bus.s_wvalid = '1;
        bus.s_wstrb = '1;
        bus.s_bready = '1;
        bus.m_awready = 1'b1;
        bus.m_wready = 1'b1;
        bus.m_bvalid = 1'b1;
        cyc = 0;
        n = 0;
        while (n < 4 && cyc < 100) begin
            #1;
            if (bus.m_awvalid && bus.m_awready) begin
                chk("grant_onehot", $onehot(bus.s_awready), 1);
                gw = bus.s_awready[1] ? 1 : 0;
                chk("grant_order", gw, gq.pop_front());
                chk("grant_addr", bus.m_awaddr, (gw == 1) ? 32'h2000 : 32'h1000);
                n++;
            end
            cyc++;
            if (n < 4) @(negedge clk);
        end
        if (n < 4) chk("grant_timeout", n, 4);
        @(negedge clk);
        bus.s_awvalid = '0;
        repeat (2) @(negedge clk);
        idle_inputs();
        #1;
        check_quiet("after_simul");

        // reset during beat 2 of an 8-beat burst
        @(negedge clk);
        bus.s_awvalid = 2'b01;
        bus.s_awaddr = {32'h0, 32'h3000};
        bus.s_awlen = {8'd0, 8'd7};
        bus.m_awready = 1'b1;
        @(negedge clk);
        #1;
        chk("rst_burst_aw", bus.m_awvalid, 1);
        @(negedge clk);
        bus.s_awvalid = '0;
        bus.s_wvalid = 2'b01;
        bus.s_wdata = {32'h0, 32'h1234_5678};
        bus.m_wready = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        chk("pre_rst_wvalid", bus.m_wvalid, 1);
        chk("pre_rst_wlast", bus.m_wlast, 0);
        reset = 1'b0;
        #1;
        check_quiet("async_rst");
        idle_inputs();
        @(negedge clk);
        reset = 1'b1;
        do_xact(1, 32'h4000, 8'd1, 2'b00, 0, 0);

        chk("aw_queue_empty", awq.size(), 0);
        chk("w_queue_empty", wq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
